// File: rtl/canny_line_stream_tx.sv
// canny_line_stream_tx
// Transmit side of the line-buffered 3x3 window interface in the canny
// pipeline. It pulls pixels from an upstream word FIFO and drives a gapless
// per-line raster stream into the 3x3 window generator. After the image it
// appends PAD_LINES zero lines so that the last image row reaches the window
// centre. It also produces a centre-valid strobe with centre coordinates that
// line up with the window register outputs.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle frame start pulse, honoured only when idle
//   s_line_avail upstream holds at least IMG_W words
//   s_valid      upstream word valid
//   s_data       upstream word
//   s_ready      upstream word consumed this cycle (when s_valid=1)
//   dout_vld     pixel strobe to window generator din_vld
//   dout         pixel to window generator din
//   ctr_vld      window centre valid
//   ctr_row      centre row
//   ctr_col      centre column
//   busy         frame in progress
//   frame_done   one-cycle pulse at end of frame
//   underrun     sticky; a pixel slot found no upstream word; cleared by start
module canny_line_stream_tx #(
    parameter int IMG_W     = 1024,
    parameter int IMG_H     = 768,
    parameter int DW        = 13,
    parameter int PAD_LINES = 1,
    parameter int HBLANK    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       s_line_avail,
    input  logic                       s_valid,
    input  logic [DW-1:0]              s_data,
    output logic                       s_ready,
    output logic                       dout_vld,
    output logic [DW-1:0]              dout,
    output logic                       ctr_vld,
    output logic [$clog2(IMG_H)-1:0]   ctr_row,
    output logic [$clog2(IMG_W)-1:0]   ctr_col,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       underrun
);

    localparam int TOTAL = IMG_H + PAD_LINES;
    localparam int RW    = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(IMG_W);
    localparam int CRW   = $clog2(IMG_H);
    localparam int BW    = $clog2(HBLANK + 2);

    localparam logic [RW-1:0] ROW_IMG    = RW'(IMG_H);
    localparam logic [RW-1:0] ROW_TOTAL  = RW'(TOTAL);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(HBLANK - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LINE = 3'd1;
    localparam logic [2:0] S_LINE      = 3'd2;
    localparam logic [2:0] S_FLUSH     = 3'd3;
    localparam logic [2:0] S_BLANK     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [RW-1:0] row_p0;
    logic [CW-1:0] col_p0;
    logic [BW-1:0] blank_cnt;
    logic [RW-1:0] row_inc;
    logic          emit_p0;
    logic          line_end;

    logic          vld_p1;
    logic [DW-1:0] dout_p1;
    logic [RW-1:0] row_p1;
    logic [CW-1:0] col_p1;
    logic [RW-1:0] row_m1;
    logic [CW-1:0] col_m1;
    logic          ctr_hit;

    // Decide where to go once a line (and its blanking) is finished, or
    // while waiting: an image line needs a full line upstream, pad lines
    // need nothing, and after the last pad line the frame is done. Jumping
    // straight into LINE/FLUSH keeps the inter-line gap at exactly HBLANK.
    function automatic logic [2:0] next_line_state(input logic [RW-1:0] r,
                                                   input logic avail);
        logic [2:0] s;
        if (r < ROW_IMG) begin
            s = avail ? S_LINE : S_WAIT_LINE;
        end else if (r < ROW_TOTAL) begin
            s = S_FLUSH;
        end else begin
            s = S_DONE;
        end
        return s;
    endfunction

    assign emit_p0    = (state == S_LINE) || (state == S_FLUSH);
    assign line_end   = emit_p0 && (col_p0 == COL_LAST);
    assign row_inc    = row_p0 + RW'(1);
    assign s_ready    = (state == S_LINE);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_WAIT_LINE;
            end
            S_WAIT_LINE: begin
                state_n = next_line_state(row_p0, s_line_avail);
            end
            S_LINE, S_FLUSH: begin
                if (col_p0 == COL_LAST) begin
                    if (HBLANK == 0) state_n = next_line_state(row_inc, s_line_avail);
                    else             state_n = S_BLANK;
                end
            end
            S_BLANK: begin
                if (blank_cnt == BLANK_LAST) state_n = next_line_state(row_p0, s_line_avail);
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ---- stage p0: frame control, row/column position of the pixel slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row_p0    <= '0;
            col_p0    <= '0;
            blank_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            state <= state_n;
            if ((state == S_IDLE) && start) begin
                row_p0   <= '0;
                col_p0   <= '0;
                underrun <= 1'b0;
            end
            if ((state == S_LINE) && !s_valid) begin
                underrun <= 1'b1;
            end
            if (emit_p0) begin
                col_p0 <= line_end ? '0 : col_p0 + CW'(1);
                if (line_end) row_p0 <= row_inc;
            end
            if ((state == S_BLANK) && (blank_cnt != BLANK_LAST)) begin
                blank_cnt <= blank_cnt + BW'(1);
            end else begin
                blank_cnt <= '0;
            end
        end
    end

    // ---- stage p1: registered pixel to the window generator ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            dout_p1 <= '0;
            row_p1  <= '0;
            col_p1  <= '0;
        end else begin
            vld_p1  <= emit_p0;
            dout_p1 <= ((state == S_LINE) && s_valid) ? s_data : '0;
            row_p1  <= row_p0;
            col_p1  <= col_p0;
        end
    end

    assign dout_vld = vld_p1;
    assign dout     = dout_p1;

    // A pixel at stream (r,c) completes the window centred on (r-1,c-1).
    // Only rows 1..IMG_H-1 and columns 1..IMG_W-2 are flagged; rows 0/1 of a
    // fresh frame never qualify, so stale taps after an abort stay hidden.
    assign row_m1  = row_p1 - RW'(1);
    assign col_m1  = col_p1 - CW'(1);
    assign ctr_hit = vld_p1 && (row_p1 >= RW'(2)) && (col_p1 >= CW'(2))
                     && (row_p1 <= ROW_IMG);

    // ---- stage p2: centre strobe aligned to the window register outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_vld <= 1'b0;
            ctr_row <= '0;
            ctr_col <= '0;
        end else begin
            ctr_vld <= ctr_hit;
            if (ctr_hit) begin
                ctr_row <= row_m1[CRW-1:0];
                ctr_col <= col_m1;
            end
        end
    end

endmodule

// File: tb/tb_canny_line_stream_tx.sv
// Testbench for canny_line_stream_tx: small 8x4 frame with one pad line.
// The upstream driver offers random (or linear) words and the reference
// model builds the expected raster stream, run/gap shape and centre list
// from plain arithmetic on the frame geometry.
module tb_canny_line_stream_tx;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int DW    = 13;
    localparam int PAD   = 1;
    localparam int HB    = 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NOUT  = IMG_W * (IMG_H + PAD);
    localparam int NCTR  = (IMG_H - 1) * (IMG_W - 2);

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic                     s_line_avail;
    logic                     s_valid;
    logic [DW-1:0]            s_data;
    logic                     s_ready;
    logic                     dout_vld;
    logic [DW-1:0]            dout;
    logic                     ctr_vld;
    logic [$clog2(IMG_H)-1:0] ctr_row;
    logic [$clog2(IMG_W)-1:0] ctr_col;
    logic                     busy;
    logic                     frame_done;
    logic                     underrun;

    canny_line_stream_tx #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .PAD_LINES(PAD), .HBLANK(HB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_line_avail(s_line_avail),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .dout_vld(dout_vld), .dout(dout), .ctr_vld(ctr_vld),
        .ctr_row(ctr_row), .ctr_col(ctr_col), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // upstream plan: slot k of the frame carries data_a[k] unless hole_a[k]
    logic [DW-1:0] data_a [NPIX];
    bit            hole_a [NPIX];
    int            k;
    bit            stall_en;
    int            stall_cnt;
    bit            start_req;
    int            xstart_at;

    // observed stream
    logic [DW-1:0] got_q [$];
    int            run_q [$];
    int            gap_q [$];
    int            ctr_q [$];
    int            cur_run, cur_gap, emit_idx, prev_idx;
    bit            had_run, prev_vld;
    int            fd_cnt, fd_gap, align_bad;

    task automatic monitor_sample();
        if (frame_done) begin
            fd_cnt++;
            fd_gap = cur_gap;
        end
        if (ctr_vld) begin
            ctr_q.push_back(int'(ctr_row) * IMG_W + int'(ctr_col));
            // centre (row,col) must follow the stream pixel (row+1,col+1) by one cycle
            if (!(prev_vld && prev_idx == (int'(ctr_row) + 1) * IMG_W + int'(ctr_col) + 1))
                align_bad++;
        end
        prev_vld = dout_vld;
        if (dout_vld) begin
            if (cur_run == 0 && had_run) gap_q.push_back(cur_gap);
            got_q.push_back(dout);
            prev_idx = emit_idx;
            emit_idx++;
            cur_run++;
            cur_gap = 0;
            had_run = 1'b1;
        end else begin
            if (cur_run > 0) begin
                run_q.push_back(cur_run);
                cur_run = 0;
            end
            if (had_run) cur_gap++;
        end
    endtask

    task automatic drive();
        start     = start_req;
        start_req = 1'b0;
        if (s_ready && k < NPIX) begin
            s_valid = !hole_a[k];
            s_data  = hole_a[k] ? DW'($urandom) : data_a[k];
            k++;
            if (k == xstart_at) start = 1'b1;
        end else begin
            // junk outside a line must never be consumed
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
        end
        if (stall_en && k == 2 * IMG_W && stall_cnt < 10) begin
            s_line_avail = 1'b0;
            stall_cnt++;
        end else begin
            s_line_avail = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_sample();
        drive();
    endtask

    task automatic prep(input bit linear, input bit stall, input int hole_slot, input int xs);
        for (int i = 0; i < NPIX; i++) begin
            data_a[i] = linear ? DW'(i) : DW'($urandom);
            hole_a[i] = 1'b0;
        end
        if (hole_slot >= 0) begin
            hole_a[hole_slot] = 1'b1;
            hole_a[$urandom_range(0, NPIX - 1)] = 1'b1;
        end
        k = 0; stall_en = stall; stall_cnt = 0; xstart_at = xs;
        got_q.delete(); run_q.delete(); gap_q.delete(); ctr_q.delete();
        cur_run = 0; cur_gap = 0; emit_idx = 0; prev_idx = -1;
        had_run = 1'b0; prev_vld = 1'b0;
        fd_cnt = 0; fd_gap = -1; align_bad = 0;
        start_req = 1'b1;
    endtask

    task automatic run_frame(input bit linear, input bit stall, input int hole_slot, input int xs);
        int  n;
        bit  any_hole;
        logic [DW-1:0] e;
        prep(linear, stall, hole_slot, xs);
        n = 0;
        while (fd_cnt == 0 && n < 600) begin
            tick();
            n++;
        end
        if (fd_cnt == 0) check_eq("frame_timeout", 0, 1);
        for (int i = 0; i < 4; i++) tick();

        any_hole = 1'b0;
        for (int i = 0; i < NPIX; i++) any_hole |= hole_a[i];

        check_eq("pix_count", got_q.size(), NOUT);
        for (int i = 0; i < NOUT && i < got_q.size(); i++) begin
            if (i < NPIX) e = hole_a[i] ? '0 : data_a[i];
            else          e = '0;
            check_eq($sformatf("pix[%0d]", i), 32'(got_q[i]), 32'(e));
        end
        check_eq("run_count", run_q.size(), IMG_H + PAD);
        foreach (run_q[i]) check_eq($sformatf("run_len[%0d]", i), run_q[i], IMG_W);
        check_eq("gap_count", gap_q.size(), IMG_H + PAD - 1);
        foreach (gap_q[i]) begin
            if (stall && i == 1) check_eq("gap_stalled_ge10", 32'(gap_q[i] >= 10), 1);
            else                 check_eq($sformatf("gap[%0d]", i), gap_q[i], HB);
        end
        check_eq("ctr_count", ctr_q.size(), NCTR);
        n = 0;
        for (int r = 1; r <= IMG_H - 1; r++) begin
            for (int c = 1; c <= IMG_W - 2; c++) begin
                if (n < ctr_q.size())
                    check_eq($sformatf("ctr[%0d]", n), ctr_q[n], r * IMG_W + c);
                n++;
            end
        end
        check_eq("ctr_align_bad", align_bad, 0);
        check_eq("frame_done_cnt", fd_cnt, 1);
        check_eq("frame_done_gap", fd_gap, HB - 1);
        check_eq("underrun", 32'(underrun), 32'(any_hole));
        check_eq("busy_after", 32'(busy), 0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; s_line_avail = 1'b1; s_valid = 1'b0; s_data = '0;
        k = 0; stall_en = 1'b0; stall_cnt = 0; start_req = 1'b0; xstart_at = -1;
        cur_run = 0; cur_gap = 0; emit_idx = 0; prev_idx = -1;
        had_run = 1'b0; prev_vld = 1'b0; fd_cnt = 0; fd_gap = -1; align_bad = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_dout_vld", 32'(dout_vld), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_ctr_vld", 32'(ctr_vld), 0);
        check_eq("rst_s_ready", 32'(s_ready), 0);
        check_eq("rst_underrun", 32'(underrun), 0);
        rst_n = 1'b1;

        // linear data, clean upstream
        run_frame(1'b1, 1'b0, -1, -1);
        // random data, upstream short of a line before line 2
        run_frame(1'b0, 1'b1, -1, -1);
        // underrun at line 1 col 3 plus a random hole; start pulsed mid-frame
        run_frame(1'b0, 1'b0, IMG_W + 3, 20);
        // clean frame: start must clear the sticky underrun
        run_frame(1'b0, 1'b0, -1, -1);

        // abort at line 2 col 4
        prep(1'b0, 1'b0, -1, -1);
        begin
            int n = 0;
            while (k < 2 * IMG_W + 4 && n < 300) begin
                tick();
                n++;
            end
            if (k < 2 * IMG_W + 4) check_eq("abort_reach_timeout", 0, 1);
        end
        check_eq("pre_abort_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_dout_vld", 32'(dout_vld), 0);
        check_eq("abort_dout", 32'(dout), 0);
        check_eq("abort_ctr_vld", 32'(ctr_vld), 0);
        check_eq("abort_s_ready", 32'(s_ready), 0);
        check_eq("abort_frame_done", 32'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // fresh frame after the abort: restarts at row 0, no stale centres
        run_frame(1'b0, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
